// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, multiplier FSM states,
// byte/half/word access codes and the EX/MEM register layout.
package ex_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;
   localparam logic [3:0] ALU_MUL  = 4'd12;
   localparam logic [3:0] ALU_SLLV = 4'd13;
   localparam logic [3:0] ALU_SRLV = 4'd14;
   localparam logic [3:0] ALU_RSVD = 4'd15;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [1:0] BHC_BYTE = 2'd0;
   localparam logic [1:0] BHC_HALF = 2'd1;
   localparam logic [1:0] BHC_WORD = 2'd2;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        mem_read;
      logic        mem_to_reg;
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [4:0]  write_reg;
      logic [1:0]  bhc;
      logic        zero;
   } exmem_t;

   localparam exmem_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/ex_iter_mul.sv
// Iterative 32x32 -> low-32 multiplier retiring RADIX_BITS multiplier bits per step.
// product_o is combinational so the caller can register it on the final step's edge.
module ex_iter_mul
   import ex_pkg::*;
#(
   parameter int unsigned RADIX_BITS = 1
)
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        kill_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] product_o
);

   localparam int unsigned STEPS    = 32 / RADIX_BITS;
   localparam logic [4:0]  LAST_CNT = 5'(STEPS - 1);

   logic [0:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] partial;

   // a_q is pre-shifted each step, so one narrow partial product per step suffices.
   assign partial   = a_q * {{(32 - RADIX_BITS){1'b0}}, b_q[RADIX_BITS-1:0]};
   assign busy_o    = (state_q == ST_BUSY);
   assign done_o    = busy_o && (cnt_q == LAST_CNT);
   assign product_o = acc_q + partial;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      if (kill_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (state_q == ST_IDLE) begin
         if (start_i) begin
            state_d = ST_BUSY;
            cnt_d   = '0;
            acc_d   = '0;
            a_d     = a_i;
            b_d     = b_i;
         end
      end else begin
         acc_d = product_o;
         a_d   = a_q << RADIX_BITS;
         b_d   = b_q >> RADIX_BITS;
         if (done_o) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         // NOTE: non-blocking so all registers sample the pre-edge values together.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM register. Define EX_MUL_EN to run ALUOp 12 on the
// iterative multiplier (stalls upstream); otherwise ALUOp 12 is reserved and Stall is 0.
module ex_mem_stage
   import ex_pkg::*;
#(
   parameter int unsigned MUL_RADIX_BITS = 1
)
(
   input  logic        Clk,
   input  logic        reset,
   input  logic        Flush,
   input  logic        RegWrite_EX,
   input  logic        MemWrite_EX,
   input  logic        MemRead_EX,
   input  logic        MemToReg_EX,
   input  logic        ALUSrc_EX,
   input  logic        RegDst_EX,
   input  logic [3:0]  ALUOp_EX,
   input  logic [31:0] readData1_EX,
   input  logic [31:0] readData2_EX,
   input  logic [31:0] signExtend_EX,
   input  logic [4:0]  RtData_EX,
   input  logic [4:0]  RdData_EX,
   input  logic [4:0]  shamt_EX,
   input  logic [1:0]  BHC_EX,
   output logic        Stall,
   output logic        RegWrite_MEM,
   output logic        MemWrite_MEM,
   output logic        MemRead_MEM,
   output logic        MemToReg_MEM,
   output logic [31:0] ALUResult_MEM,
   output logic [31:0] WriteData_MEM,
   output logic [4:0]  WriteReg_MEM,
   output logic [1:0]  BHC_MEM,
   output logic        Zero_MEM
);

   if (!(MUL_RADIX_BITS == 1 || MUL_RADIX_BITS == 2 || MUL_RADIX_BITS == 4)) begin : g_bad_radix
      $error("MUL_RADIX_BITS must be 1, 2 or 4");
   end

   logic [31:0] op_b;
   logic [31:0] alu_result;
   exmem_t      alu_out;
   exmem_t      exmem_d, exmem_q;

   assign op_b = ALUSrc_EX ? signExtend_EX : readData2_EX;

   always_comb begin
      alu_result = '0;
      case (ALUOp_EX)
         ALU_ADD:  alu_result = readData1_EX + op_b;
         ALU_SUB:  alu_result = readData1_EX - op_b;
         ALU_AND:  alu_result = readData1_EX & op_b;
         ALU_OR:   alu_result = readData1_EX | op_b;
         ALU_XOR:  alu_result = readData1_EX ^ op_b;
         ALU_NOR:  alu_result = ~(readData1_EX | op_b);
         ALU_SLT:  alu_result = {31'b0, $signed(readData1_EX) < $signed(op_b)};
         ALU_SLTU: alu_result = {31'b0, readData1_EX < op_b};
         ALU_SLL:  alu_result = op_b << shamt_EX;
         ALU_SRL:  alu_result = op_b >> shamt_EX;
         ALU_SRA:  alu_result = $unsigned($signed(op_b) >>> shamt_EX);
         ALU_LUI:  alu_result = op_b << 16;
         ALU_SLLV: alu_result = op_b << readData1_EX[4:0];
         ALU_SRLV: alu_result = op_b >> readData1_EX[4:0];
         default:  alu_result = '0;
      endcase
   end

   always_comb begin
      alu_out.reg_write  = RegWrite_EX;
      alu_out.mem_write  = MemWrite_EX;
      alu_out.mem_read   = MemRead_EX;
      alu_out.mem_to_reg = MemToReg_EX;
      alu_out.alu_result = alu_result;
      alu_out.write_data = readData2_EX;
      alu_out.write_reg  = RegDst_EX ? RdData_EX : RtData_EX;
      alu_out.bhc        = BHC_EX;
      alu_out.zero       = (alu_result == 32'd0);
   end

`ifdef EX_MUL_EN
   logic        mul_start;
   logic        mul_busy;
   logic        mul_done;
   logic [31:0] mul_product;
   exmem_t      cap_d, cap_q;

   assign mul_start = reset && !Flush && !mul_busy && (ALUOp_EX == ALU_MUL) && RegWrite_EX;
   // Final step drops Stall so upstream advances on the same edge the product lands.
   assign Stall     = reset && !Flush && (mul_busy ? !mul_done : mul_start);

   ex_iter_mul #(
      .RADIX_BITS (MUL_RADIX_BITS)
   ) u_mul (
      .clk_i     (Clk),
      .rst_n_i   (reset),
      .start_i   (mul_start),
      .kill_i    (Flush),
      .a_i       (readData1_EX),
      .b_i       (op_b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_product)
   );

   always_comb begin
      cap_d   = cap_q;
      exmem_d = EXMEM_BUBBLE;
      if (Flush) begin
         exmem_d = EXMEM_BUBBLE;
      end else if (mul_done) begin
         exmem_d            = cap_q;
         exmem_d.alu_result = mul_product;
         exmem_d.zero       = (mul_product == 32'd0);
      end else if (mul_start) begin
         cap_d = alu_out;
      end else if (!mul_busy) begin
         exmem_d = alu_out;
      end
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         cap_q <= EXMEM_BUBBLE;
      end else begin
         cap_q <= cap_d;
      end
   end
`else
   assign Stall   = 1'b0;
   assign exmem_d = Flush ? EXMEM_BUBBLE : alu_out;
`endif

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         exmem_q <= EXMEM_BUBBLE;
      end else begin
         exmem_q <= exmem_d;
      end
   end

   assign RegWrite_MEM  = exmem_q.reg_write;
   assign MemWrite_MEM  = exmem_q.mem_write;
   assign MemRead_MEM   = exmem_q.mem_read;
   assign MemToReg_MEM  = exmem_q.mem_to_reg;
   assign ALUResult_MEM = exmem_q.alu_result;
   assign WriteData_MEM = exmem_q.write_data;
   assign WriteReg_MEM  = exmem_q.write_reg;
   assign BHC_MEM       = exmem_q.bhc;
   assign Zero_MEM      = exmem_q.zero;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: driver pushes per-cycle expectations from a
// behavioural model; a negedge monitor pops and compares EX/MEM outputs and Stall.
`timescale 1ns/1ps
module tb_ex_mem_stage;

   localparam int unsigned RADIX = 1;
   localparam int unsigned N     = 32 / RADIX;
`ifdef EX_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct packed {
      logic        rw, mw, mr, m2r, alusrc, regdst;
      logic [3:0]  op;
      logic [31:0] a, b, imm;
      logic [4:0]  rt, rd, shamt;
      logic [1:0]  bhc;
   } instr_t;

   typedef struct packed {
      logic        rw, mw, mr, m2r;
      logic [31:0] res, wd;
      logic [4:0]  wr;
      logic [1:0]  bhc;
      logic        zero;
   } out_t;

   typedef struct packed {
      out_t out;
      logic stall;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        rw_ex = 1'b0, mw_ex = 1'b0, mr_ex = 1'b0, m2r_ex = 1'b0, alusrc_ex = 1'b0, regdst_ex = 1'b0;
   logic [3:0]  op_ex = '0;
   logic [31:0] a_ex = '0, b_ex = '0, imm_ex = '0;
   logic [4:0]  rt_ex = '0, rd_ex = '0, shamt_ex = '0;
   logic [1:0]  bhc_ex = '0;
   logic        stall;
   logic        rw_mem, mw_mem, mr_mem, m2r_mem, zero_mem;
   logic [31:0] res_mem, wd_mem;
   logic [4:0]  wr_mem;
   logic [1:0]  bhc_mem;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   int stall_hi  = 0;
   int prod_hits = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   ex_mem_stage #(.MUL_RADIX_BITS(RADIX)) dut (
      .Clk(clk), .reset(rst_n), .Flush(flush),
      .RegWrite_EX(rw_ex), .MemWrite_EX(mw_ex), .MemRead_EX(mr_ex), .MemToReg_EX(m2r_ex),
      .ALUSrc_EX(alusrc_ex), .RegDst_EX(regdst_ex), .ALUOp_EX(op_ex),
      .readData1_EX(a_ex), .readData2_EX(b_ex), .signExtend_EX(imm_ex),
      .RtData_EX(rt_ex), .RdData_EX(rd_ex), .shamt_EX(shamt_ex), .BHC_EX(bhc_ex),
      .Stall(stall),
      .RegWrite_MEM(rw_mem), .MemWrite_MEM(mw_mem), .MemRead_MEM(mr_mem), .MemToReg_MEM(m2r_mem),
      .ALUResult_MEM(res_mem), .WriteData_MEM(wd_mem), .WriteReg_MEM(wr_mem),
      .BHC_MEM(bhc_mem), .Zero_MEM(zero_mem)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cycle, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   out_t   m_out = '0;
   out_t   m_cap = '0;
   bit     m_busy = 1'b0;
   int     m_left = 0;
   instr_t prev_i = '0;
   logic   prev_fl = 1'b0;
   logic   prev_rst = 1'b0;

   function automatic logic [31:0] operand_b(input instr_t i);
      return i.alusrc ? i.imm : i.b;
   endfunction

   function automatic logic [31:0] ref_alu(input instr_t i);
      logic [31:0] b;
      b = operand_b(i);
      case (i.op)
         4'd0:  return i.a + b;
         4'd1:  return i.a - b;
         4'd2:  return i.a & b;
         4'd3:  return i.a | b;
         4'd4:  return i.a ^ b;
         4'd5:  return ~(i.a | b);
         4'd6:  return ($signed(i.a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd7:  return (i.a < b) ? 32'd1 : 32'd0;
         4'd8:  return b << i.shamt;
         4'd9:  return b >> i.shamt;
         4'd10: return $signed(b) >>> i.shamt;
         4'd11: return b << 16;
         4'd13: return b << i.a[4:0];
         4'd14: return b >> i.a[4:0];
         default: return 32'd0;
      endcase
   endfunction

   function automatic out_t ref_single(input instr_t i, input logic [31:0] res);
      out_t o;
      o.rw = i.rw; o.mw = i.mw; o.mr = i.mr; o.m2r = i.m2r;
      o.res = res; o.wd = i.b; o.wr = i.regdst ? i.rd : i.rt;
      o.bhc = i.bhc; o.zero = (res == 32'd0);
      return o;
   endfunction

   function automatic bit is_mul(input instr_t i);
      return MUL_EN && (i.op == 4'd12) && i.rw;
   endfunction

   task automatic model_edge();
      if (!prev_rst) begin
         m_out = '0; m_busy = 1'b0; m_left = 0;
      end else if (prev_fl) begin
         m_out = '0; m_busy = 1'b0;
      end else if (m_busy) begin
         if (m_left == 1) begin
            m_out = m_cap; m_busy = 1'b0;
         end else begin
            m_left--; m_out = '0;
         end
      end else if (is_mul(prev_i)) begin
         m_cap  = ref_single(prev_i, prev_i.a * operand_b(prev_i));
         m_busy = 1'b1; m_left = N; m_out = '0;
      end else begin
         m_out = ref_single(prev_i, ref_alu(prev_i));
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input instr_t i, input logic fl, input logic r, output logic st);
      exp_t e;
      @(posedge clk);
      #1;
      cycle++;
      model_edge();
      rst_n = r; flush = fl;
      rw_ex = i.rw; mw_ex = i.mw; mr_ex = i.mr; m2r_ex = i.m2r;
      alusrc_ex = i.alusrc; regdst_ex = i.regdst; op_ex = i.op;
      a_ex = i.a; b_ex = i.b; imm_ex = i.imm;
      rt_ex = i.rt; rd_ex = i.rd; shamt_ex = i.shamt; bhc_ex = i.bhc;
      if (!r) begin
         m_out = '0; m_busy = 1'b0; m_left = 0;
      end
      st = r && !fl && (m_busy ? (m_left > 1) : is_mul(i));
      e.out = m_out; e.stall = st;
      sb.push_back(e);
      prev_i = i; prev_fl = fl; prev_rst = r;
   endtask

   task automatic issue(input instr_t i);
      logic st;
      for (int g = 0; g < 4 * N + 4; g++) begin
         step(i, 1'b0, 1'b1, st);
         if (!st) break;
      end
   endtask

   function automatic instr_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic alusrc, input logic [4:0] shamt);
      instr_t i;
      i.rw = 1'b1; i.mw = 1'b0; i.mr = 1'b0; i.m2r = 1'b0;
      i.alusrc = alusrc; i.regdst = 1'b1; i.op = op;
      i.a = a; i.b = b; i.imm = imm;
      i.rt = 5'd3; i.rd = 5'd9; i.shamt = shamt; i.bhc = 2'd2;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      i.op = 4'($urandom_range(0, 15));
      if (i.op == 4'd12) i.rw = 1'b1;
      if ($urandom_range(0, 5) == 0) begin
         i.b = i.a; i.alusrc = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) i.a = 32'($urandom_range(0, 40));
      return i;
   endfunction

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      out_t act;
      forever begin
         @(negedge clk);
         if (stall === 1'b1) stall_hi++;
         if (rw_mem === 1'b1 && res_mem === 32'hFFFF_FFEB) prod_hits++;
         if (sb.size() != 0) begin
            e   = sb.pop_front();
            act = {rw_mem, mw_mem, mr_mem, m2r_mem, res_mem, wd_mem, wr_mem, bhc_mem, zero_mem};
            check("exmem_out", 128'(act), 128'(e.out));
            check("stall", 128'(stall), 128'(e.stall));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cycle);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic   st;
      instr_t cur;
      instr_t nop;
      instr_t mul_a, mul_b;
      nop   = mk(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd0);
      mul_a = mk(4'd12, 32'd3, 32'd5, 32'd0, 1'b0, 5'd0);

      // Reset held with a multiply presented: outputs and Stall stay 0.
      for (int k = 0; k < 3; k++) step(mk(4'd12, 32'd7, 32'd9, 32'd0, 1'b0, 5'd0), 1'b0, 1'b0, st);

      stall_hi = 0;
      issue(mk(4'd0,  32'd5,          32'd0,          32'hFFFF_FFFD, 1'b1, 5'd0));
      issue(mk(4'd6,  32'hFFFF_FFFF,  32'd1,          32'd0,         1'b0, 5'd0));
      issue(mk(4'd7,  32'hFFFF_FFFF,  32'd1,          32'd0,         1'b0, 5'd0));
      issue(mk(4'd1,  32'd7,          32'd7,          32'd0,         1'b0, 5'd0));
      issue(mk(4'd10, 32'd0,          32'h8000_0000,  32'd0,         1'b0, 5'd4));
      issue(mk(4'd14, 32'd4,          32'h8000_0000,  32'd0,         1'b0, 5'd0));
      issue(nop);
      @(negedge clk); #1;
      check("single_cycle_no_stall", 128'(stall_hi), 128'(0));

      // Multiply 7 * 0xFFFFFFFD: N stall cycles and exactly one product write.
      stall_hi = 0; prod_hits = 0;
      issue(mk(4'd12, 32'd7, 32'hFFFF_FFFD, 32'd0, 1'b0, 5'd0));
      issue(mk(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0));
      issue(nop);
      @(negedge clk); #1;
      check("mul_stall_cycles", 128'(stall_hi), 128'(MUL_EN ? N : 0));
      check("mul_product_once", 128'(prod_hits), 128'(MUL_EN ? 1 : 0));

      // Flush in the busy cycle with count 10, then a normal ADD.
      step(mul_a, 1'b0, 1'b1, st);
      for (int k = 0; k < 10; k++) step(mul_a, 1'b0, 1'b1, st);
      step(mul_a, 1'b1, 1'b1, st);
      issue(mk(4'd0, 32'd100, 32'd23, 32'd0, 1'b0, 5'd0));
      issue(nop);

      // Reset in the busy cycle with count 5; no product may follow.
      mul_b = mk(4'd12, 32'd11, 32'd13, 32'd0, 1'b0, 5'd0);
      step(mul_b, 1'b0, 1'b1, st);
      for (int k = 0; k < 5; k++) step(mul_b, 1'b0, 1'b1, st);
      step(mul_b, 1'b0, 1'b0, st);
      step(nop, 1'b0, 1'b0, st);
      for (int k = 0; k < N + 4; k++) issue(nop);

      // Random traffic with occasional flushes; upstream holds while Stall is expected.
      cur = rand_instr();
      for (int n = 0; n < 400; ) begin
         step(cur, ($urandom_range(0, 24) == 0), 1'b1, st);
         if (!st) begin
            cur = rand_instr();
            n++;
         end
      end
      issue(nop);
      issue(nop);
      @(negedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
